// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared types and constants for the text console path
package vga_text_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLR_ALL = 2'd1,
        ST_CLR_ROW = 2'd2
    } console_state_t;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;

    // Default geometry, also used by the font renderer and sync generator
    localparam int         TEXT_COLS  = 80;
    localparam int         TEXT_ROWS  = 30;
    localparam int         TEXT_COL_W = 7;
    localparam int         TEXT_ROW_W = 5;
    localparam logic [7:0] TEXT_FILL  = 8'h20;

endpackage

// File: rtl/text_cell_ram.sv
// rtl/text_cell_ram.sv - simple dual-port cell store with registered, range-gated read
module text_cell_ram #(
    parameter int DEPTH  = 2400,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Out-of-range reads return zero; same-cycle write is not forwarded
    always_ff @(posedge clk) begin
        if (!resetn)
            rdata <= '0;
        else if (rd_en)
            rdata <= mem[raddr];
        else
            rdata <= '0;
    end

endmodule

// File: rtl/vga_text_console.sv
// rtl/vga_text_console.sv - character grid with cursor writer, circular scroll and clear engines
module vga_text_console
    import vga_text_pkg::*;
#(
    parameter int                COLS      = TEXT_COLS,
    parameter int                ROWS      = TEXT_ROWS,
    parameter int                DATA_W    = 8,
    parameter int                COL_W     = TEXT_COL_W,
    parameter int                ROW_W     = TEXT_ROW_W,
    parameter logic [DATA_W-1:0] FILL_CHAR = DATA_W'(TEXT_FILL)
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Char_DV,
    input  logic [DATA_W-1:0] i_Char,
    input  logic              i_Clear,
    output logic              o_Busy,
    input  logic [COL_W-1:0]  i_Rd_Col,
    input  logic [ROW_W-1:0]  i_Rd_Row,
    output logic [DATA_W-1:0] o_Rd_Data,
    output logic [COL_W-1:0]  o_Cursor_Col,
    output logic [ROW_W-1:0]  o_Cursor_Row,
    output logic [ROW_W-1:0]  o_Top_Row
);

    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [COL_W:0]    COLS_X    = (COL_W+1)'(COLS);
    localparam logic [ROW_W:0]    ROWS_X    = (ROW_W+1)'(ROWS);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS - 1);

    // Logical row to physical row; operands are both below ROWS so one subtract suffices
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] row,
                                                  input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= ROWS_X)
            sum = sum - ROWS_X;
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * COLS_A + ADDR_W'(col);
    endfunction

    console_state_t    state, state_n;
    logic [COL_W-1:0]  cur_col, col_n;
    logic [ROW_W-1:0]  cur_row, row_n;
    logic [ROW_W-1:0]  top_row, top_n;
    logic [ADDR_W-1:0] clr_cnt, cnt_n;
    logic [ADDR_W-1:0] clr_base, base_n;
    logic              newline;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state    <= ST_IDLE;
            cur_col  <= '0;
            cur_row  <= '0;
            top_row  <= '0;
            clr_cnt  <= '0;
            clr_base <= '0;
        end else begin
            state    <= state_n;
            cur_col  <= col_n;
            cur_row  <= row_n;
            top_row  <= top_n;
            clr_cnt  <= cnt_n;
            clr_base <= base_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = cur_col;
        row_n   = cur_row;
        top_n   = top_row;
        cnt_n   = clr_cnt;
        base_n  = clr_base;
        newline = 1'b0;
        wr_en   = 1'b0;
        wr_addr = cell_addr(phys_row(cur_row, top_row), cur_col);
        wr_data = i_Char;
        case (state)
            ST_IDLE: begin
                if (i_Clear) begin
                    state_n = ST_CLR_ALL;
                    cnt_n   = '0;
                end else if (i_Char_DV) begin
                    if (i_Char == DATA_W'(CH_LF)) begin
                        col_n   = '0;
                        newline = 1'b1;
                    end else if (i_Char == DATA_W'(CH_CR)) begin
                        col_n = '0;
                    end else if (i_Char == DATA_W'(CH_BS)) begin
                        if (cur_col != '0)
                            col_n = cur_col - 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (cur_col == LAST_COL) begin
                            col_n   = '0;
                            newline = 1'b1;
                        end else begin
                            col_n = cur_col + 1'b1;
                        end
                    end
                end
            end
            ST_CLR_ALL: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt;
                wr_data = FILL_CHAR;
                if (clr_cnt == LAST_ADDR) begin
                    state_n = ST_IDLE;
                    col_n   = '0;
                    row_n   = '0;
                    top_n   = '0;
                end else begin
                    cnt_n = clr_cnt + 1'b1;
                end
            end
            ST_CLR_ROW: begin
                wr_en   = 1'b1;
                wr_addr = clr_base + clr_cnt;
                wr_data = FILL_CHAR;
                if (clr_cnt == LAST_CELL)
                    state_n = ST_IDLE;
                else
                    cnt_n = clr_cnt + 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase

        // At the bottom the old top physical row becomes the new bottom and is wiped
        if (newline) begin
            if (cur_row != LAST_ROW) begin
                row_n = cur_row + 1'b1;
            end else begin
                top_n   = (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
                base_n  = cell_addr(top_row, '0);
                cnt_n   = '0;
                state_n = ST_CLR_ROW;
            end
        end
    end

    assign rd_valid = ({1'b0, i_Rd_Col} < COLS_X) && ({1'b0, i_Rd_Row} < ROWS_X);
    assign rd_addr  = cell_addr(phys_row(i_Rd_Row, top_row), i_Rd_Col);

    text_cell_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_cell_ram (
        .clk    (i_Clk),
        .resetn (i_Rst_L),
        .we     (wr_en & i_Rst_L),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .rd_en  (rd_valid),
        .raddr  (rd_addr),
        .rdata  (o_Rd_Data)
    );

    assign o_Busy       = (state != ST_IDLE);
    assign o_Cursor_Col = cur_col;
    assign o_Cursor_Row = cur_row;
    assign o_Top_Row    = top_row;

endmodule

// File: tb/tb_vga_text_console.sv
// tb/tb_vga_text_console.sv - self-checking bench for vga_text_console
module tb_vga_text_console;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam logic [7:0] FILL = 8'h20;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       char_dv = 1'b0;
    logic [7:0] ch = 8'h00;
    logic       clr = 1'b0;
    logic       busy;
    logic [6:0] rd_col = '0;
    logic [4:0] rd_row = '0;
    logic [7:0] rd_data;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic [4:0] top_row;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    vga_text_console dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_Char_DV    (char_dv),
        .i_Char       (ch),
        .i_Clear      (clr),
        .o_Busy       (busy),
        .i_Rd_Col     (rd_col),
        .i_Rd_Row     (rd_row),
        .o_Rd_Data    (rd_data),
        .o_Cursor_Col (cur_col),
        .o_Cursor_Row (cur_row),
        .o_Top_Row    (top_row)
    );

    // Logical screen model: scrolling shifts rows up and appends a blank row
    logic [7:0] screen [ROWS][COLS];
    int         m_col = 0, m_row = 0, m_top = 0, m_busy = 0;
    bit         m_home = 0, m_known = 0, m_valid = 0, m_rd_chk = 0;
    logic [7:0] m_rd = 8'h00;

    always @(posedge clk) begin
        if (!rst_l) begin
            if (m_busy > 0) m_known = 0;
            m_busy = 0; m_home = 0; m_col = 0; m_row = 0; m_top = 0;
            m_rd = 8'h00; m_rd_chk = 1; m_valid = 1;
        end else if (m_valid) begin
            if (rd_col >= COLS || rd_row >= ROWS) begin
                m_rd = 8'h00; m_rd_chk = 1;
            end else if (m_known && m_busy == 0) begin
                m_rd = screen[rd_row][rd_col]; m_rd_chk = 1;
            end else begin
                m_rd_chk = 0;
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0 && m_home) begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++) screen[r][c] = FILL;
                    m_col = 0; m_row = 0; m_top = 0; m_home = 0; m_known = 1;
                end
            end else if (clr) begin
                m_busy = COLS * ROWS; m_home = 1;
            end else if (char_dv) begin
                bit nl;
                nl = 0;
                case (ch)
                    8'h0A: begin m_col = 0; nl = 1; end
                    8'h0D: m_col = 0;
                    8'h08: if (m_col > 0) m_col--;
                    default: begin
                        screen[m_row][m_col] = ch;
                        if (m_col == COLS - 1) begin m_col = 0; nl = 1; end
                        else m_col++;
                    end
                endcase
                if (nl) begin
                    if (m_row < ROWS - 1) m_row++;
                    else begin
                        for (int r = 0; r < ROWS - 1; r++)
                            for (int c = 0; c < COLS; c++) screen[r][c] = screen[r+1][c];
                        for (int c = 0; c < COLS; c++) screen[ROWS-1][c] = FILL;
                        m_top = (m_top + 1) % ROWS;
                        m_busy = COLS;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", int'(busy), int'(m_busy > 0));
            chk("cursor_col", int'(cur_col), m_col);
            chk("cursor_row", int'(cur_row), m_row);
            chk("top_row", int'(top_row), m_top);
            if (m_rd_chk) chk("rd_data", int'(rd_data), int'(m_rd));
        end
    end

    task automatic send(input logic [7:0] c);
        @(negedge clk); char_dv = 1'b1; ch = c;
        @(negedge clk); char_dv = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Counts busy cycles from the current negedge while sweeping read addresses
    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 5000) begin
            rd_col = 7'(n % 81); rd_row = 5'((n / 81) % 31);
            n++;
            @(negedge clk);
        end
        if (n >= 5000) chk({name, "_timeout"}, n, 0);
    endtask

    task automatic check_cell(input int c, input int r, input logic [7:0] exp, input string name);
        @(negedge clk); rd_col = 7'(c); rd_row = 5'(r);
        @(negedge clk); chk(name, int'(rd_data), int'(exp));
    endtask

    int n;
    logic [7:0] c80;

    initial begin
        // 1: reset and full clear
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_col", int'(cur_col), 0);
        chk("rst_top", int'(top_row), 0);
        chk("rst_rd", int'(rd_data), 0);
        pulse_clear();
        wait_idle("clr_all", n);
        chk("clr_all_cycles", n, 2400);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) check_cell(c, r, FILL, "clr_cell");
        chk("clr_cursor_row", int'(cur_row), 0);

        // 2: "AB", LF, "C"
        send(8'h41); send(8'h42); send(8'h0A); send(8'h43);
        check_cell(0, 0, 8'h41, "cell_0_0");
        check_cell(1, 0, 8'h42, "cell_1_0");
        check_cell(0, 1, 8'h43, "cell_0_1");
        chk("ab_c_col", int'(cur_col), 1);
        chk("ab_c_row", int'(cur_row), 1);

        // 3: 81 printable chars wrap, then backspaces
        pulse_clear();
        wait_idle("clr_all2", n);
        for (int i = 0; i < 81; i++) send(8'h21 + 8'(i % 90));
        c80 = 8'h71;
        check_cell(79, 0, 8'h70, "row0_last");
        check_cell(0, 1, c80, "wrap_cell");
        chk("wrap_col", int'(cur_col), 1);
        chk("wrap_row", int'(cur_row), 1);
        send(8'h08); send(8'h08);
        chk("bs_col", int'(cur_col), 0);
        check_cell(0, 1, c80, "bs_cell");

        // 4: LF at bottom scrolls and clears one row
        for (int i = 0; i < 28; i++) send(8'h0A);
        chk("bottom_row", int'(cur_row), 29);
        @(negedge clk); char_dv = 1'b1; ch = 8'h0A;
        @(negedge clk); char_dv = 1'b0;
        wait_idle("clr_row", n);
        chk("clr_row_cycles", n, 80);
        chk("scroll_top", int'(top_row), 1);
        check_cell(0, 0, c80, "scrolled_row0");
        for (int c = 0; c < COLS; c++) check_cell(c, 29, FILL, "new_bottom");
        for (int i = 0; i < 80; i++) send(8'h41 + 8'(i % 26));
        wait_idle("clr_row2", n);
        chk("wrap_scroll_top", int'(top_row), 2);
        check_cell(0, 28, 8'h41, "wrapped_line");
        check_cell(79, 28, 8'h41 + 8'(79 % 26), "wrapped_line_end");

        // 5: clear beats char, chars during busy dropped
        @(negedge clk); clr = 1'b1; char_dv = 1'b1; ch = 8'h58;
        @(negedge clk); clr = 1'b0; char_dv = 1'b0;
        for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 8'h59 : 8'h0A);
        chk("busy_cursor_row", int'(cur_row), 29);
        wait_idle("clr_all3", n);
        check_cell(0, 0, FILL, "no_char_written");
        check_cell(0, 29, FILL, "no_char_bottom");
        chk("home_col", int'(cur_col), 0);

        // 6: out-of-range reads, reset mid-clear
        check_cell(80, 0, 8'h00, "oor_col");
        check_cell(0, 30, 8'h00, "oor_row");
        send(8'h5A);
        pulse_clear();
        repeat (100) @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_col", int'(cur_col), 0);
        chk("mid_rst_row", int'(cur_row), 0);
        chk("mid_rst_top", int'(top_row), 0);
        chk("mid_rst_rd", int'(rd_data), 0);
        rst_l = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Character-cell screen store for the VGA font path. Generalises the fixed 2400x8 text buffer to a parametrised COLS x ROWS grid.
- Adds a cursor-driven character writer that handles control codes.
- Adds hardware scrolling through a circular top-row pointer, plus row-clear and full-screen-clear engines.
- The font renderer reads by logical (col,row); the console performs the scroll translation internally.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, character rows
- DATA_W, 8, bits per cell (character code)
- COL_W, 7, column index width; must satisfy 2^COL_W >= COLS
- ROW_W, 5, row index width; must satisfy 2^ROW_W >= ROWS
- FILL_CHAR, 8'h20, value written by clear operations

Ports:
- i_Clk  in  1  sole clock
- i_Rst_L  in  1  synchronous reset, active low
- i_Char_DV  in  1  one-cycle strobe: i_Char valid
- i_Char  in  DATA_W  character or control code
- i_Clear  in  1  one-cycle strobe: clear screen, home cursor
- o_Busy  out  1  high while a clear engine is running; writer inputs are ignored
- i_Rd_Col  in  COL_W  renderer logical column
- i_Rd_Row  in  ROW_W  renderer logical row
- o_Rd_Data  out  DATA_W  cell contents, 1-cycle latency
- o_Cursor_Col  out  COL_W  current cursor column
- o_Cursor_Row  out  ROW_W  current cursor row (logical)
- o_Top_Row  out  ROW_W  physical row shown as logical row 0

Behaviour:
- Clocking and reset:
  - One clock only.
  - i_Rst_L sampled on the rising edge of i_Clk; reset is synchronous, active-low.
  - Reset values: o_Rd_Data=0, o_Cursor_Col=0, o_Cursor_Row=0, o_Top_Row=0, o_Busy=0, FSM=IDLE.
  - Memory contents are not reset; software issues i_Clear after reset.
  - Reset mid-clear aborts the clear immediately; cells already filled stay filled.
- Storage: COLS*ROWS cells. Physical address = phys_row*COLS + col, where phys_row = (row + o_Top_Row) mod ROWS, computed without division (compare-and-subtract).
- Read port:
  - o_Rd_Data registered one cycle after i_Rd_Col/i_Rd_Row.
  - Returns 0 if col>=COLS or row>=ROWS.
  - Reads are always allowed, including while busy (may return partially cleared contents).
  - Read and write to the same cell in the same cycle: read returns the old data.
- FSM states:
  - IDLE: accepts i_Clear and i_Char_DV. If both arrive in the same cycle, clear wins and the char is dropped.
  - CLR_ALL: writes FILL_CHAR to physical cells 0..COLS*ROWS-1, one per cycle (COLS*ROWS cycles). On exit: cursor=(0,0), o_Top_Row=0, go to IDLE.
  - CLR_ROW: writes FILL_CHAR to the COLS cells of the physical row just exposed by a scroll, one per cycle, then go to IDLE.
- o_Busy: high in CLR_ALL and CLR_ROW, combinationally from state. i_Char_DV and i_Clear are ignored (dropped) while busy; upstream must gate on o_Busy.
- Writer, in IDLE on i_Char_DV:
  - 8'h0A (LF): col=0; newline.
  - 8'h0D (CR): col=0; row unchanged.
  - 8'h08 (BS): if col>0 then col-1, no memory write; at col 0 nothing happens.
  - Any other code: write to the cursor cell, then col+1. If col was COLS-1: col=0 and newline.
- Newline:
  - If row<ROWS-1: row+1.
  - If row==ROWS-1: row stays ROWS-1; o_Top_Row=(o_Top_Row+1) mod ROWS; enter CLR_ROW for the old top physical row, which is now the bottom row.
- Write latency: a char accepted in cycle N is visible to a read issued in cycle N+1; the cursor outputs update in cycle N+1.

Decomposition:
- Package vga_text_pkg:
  - FSM state enum (IDLE, CLR_ALL, CLR_ROW)
  - Control-code constants (LF, CR, BS)
  - Default geometry constants shared with the font renderer and the sync generator
- Sub-module text_cell_ram: simple dual-port RAM (one write port, one registered read port), DEPTH=COLS*ROWS, width DATA_W, with the out-of-range read returning 0.
- The console holds the FSM, cursor, scroll pointer and address arithmetic.

Test Plan:
1. Reset, then i_Clear -> o_Busy high for exactly 2400 cycles. All 2400 cells then read 8'h20; cursor (0,0); o_Top_Row 0.
2. After clear, write "AB", LF, "C" -> cell (0,0)=8'h41, (1,0)=8'h42, (0,1)=8'h43; cursor=(1,1).
3. Write 81 printable chars from (0,0) -> row 0 full; (0,1)=81st char; cursor=(1,1). Then BS twice -> cursor (0,1), cell (0,1) unchanged.
4. Cursor at row 29, send LF -> o_Top_Row=1; o_Busy high for 80 cycles. Logical row 29 reads all 8'h20; logical row 0 shows the old row 1 contents.
5. In IDLE, assert i_Clear and i_Char_DV in the same cycle -> no char written, CLR_ALL runs. i_Char_DV pulses during busy are dropped and the cursor does not move.
6. Read (80,0) and (0,30) -> o_Rd_Data=0. Deassert i_Rst_L mid-CLR_ALL -> next cycle o_Busy=0, all outputs at reset values.
